// File: rtl/color_shape_classifier.sv
// ============================================================================
// Module   : color_shape_classifier
// Purpose  : Per-frame red/blue ROI pixel counter with colour and shape
//            classification, reporting one result strobe per frame end.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module color_shape_classifier #(
    parameter int         SCREEN_WIDTH  = 176,
    parameter int         SCREEN_HEIGHT = 144,
    parameter int         ROI_X0        = 38,
    parameter int         ROI_X1        = 138,
    parameter int         ROI_Y0        = 24,
    parameter int         ROI_Y1        = 120,
    parameter int         CNT_W         = 16,
    parameter logic [2:0] R_MIN         = 3'd4,
    parameter logic [1:0] B_MIN         = 2'd2,
    parameter int         TOL_SHIFT     = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [7:0]       PIXEL_IN,
    input  logic [9:0]       VGA_PIXEL_X,
    input  logic [9:0]       VGA_PIXEL_Y,
    input  logic             VGA_HREF_NEG,
    input  logic             VGA_VSYNC_NEG,
    input  logic [CNT_W-1:0] R_THRESH,
    input  logic [CNT_W-1:0] B_THRESH,
    output logic [1:0]       RESULT_COLOR,
    output logic [1:0]       RESULT_SHAPE,
    output logic             RESULT_VALID,
    output logic [7:0]       FRAME_CNT
);

    localparam int         c_BAND_H = (ROI_Y1 - ROI_Y0) / 3;
    localparam logic [9:0] c_X0     = 10'(ROI_X0);
    localparam logic [9:0] c_X1     = 10'(ROI_X1);
    localparam logic [9:0] c_Y0     = 10'(ROI_Y0);
    localparam logic [9:0] c_Y1     = 10'(ROI_Y1);
    localparam logic [9:0] c_B1     = 10'(ROI_Y0 + c_BAND_H);
    localparam logic [9:0] c_B2     = 10'(ROI_Y0 + 2 * c_BAND_H);
    // An ROI that does not fit the screen or is too short for three bands never counts.
    localparam logic       c_CFG_OK = (ROI_X0 < ROI_X1) && (ROI_X1 <= SCREEN_WIDTH) &&
                                      (ROI_Y1 - ROI_Y0 >= 3) && (ROI_Y1 <= SCREEN_HEIGHT);
    localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] c_COL_NONE = 2'b00;
    localparam logic [1:0] c_COL_RED  = 2'b01;
    localparam logic [1:0] c_COL_BLUE = 2'b10;
    localparam logic [1:0] c_SHP_UNK  = 2'b00;
    localparam logic [1:0] c_SHP_TRI  = 2'b01;
    localparam logic [1:0] c_SHP_SQR  = 2'b10;
    localparam logic [1:0] c_SHP_DIA  = 2'b11;

    logic [CNT_W-1:0] r_red_cnt  [3];
    logic [CNT_W-1:0] r_blu_cnt  [3];
    logic [CNT_W-1:0] r_red_snap [3];
    logic [CNT_W-1:0] r_blu_snap [3];
    logic [CNT_W-1:0] r_rth;
    logic [CNT_W-1:0] r_bth;
    logic             r_vs_hist;
    logic             r_pend;

    logic             w_in_roi;
    logic             w_count;
    logic             w_red;
    logic             w_blue;
    logic [1:0]       w_band;
    logic             w_event;
    logic             w_unused_green;

    assign w_unused_green = ^PIXEL_IN[4:2];

    assign w_in_roi = c_CFG_OK &&
                      (VGA_PIXEL_X >= c_X0) && (VGA_PIXEL_X < c_X1) &&
                      (VGA_PIXEL_Y >= c_Y0) && (VGA_PIXEL_Y < c_Y1);
    assign w_count  = VGA_HREF_NEG && w_in_roi;
    assign w_red    = w_count && (PIXEL_IN[7:5] >= R_MIN) && (PIXEL_IN[1:0] < B_MIN);
    assign w_blue   = w_count && (PIXEL_IN[1:0] >= B_MIN) && (PIXEL_IN[7:5] < R_MIN);
    assign w_band   = (VGA_PIXEL_Y < c_B1) ? 2'd0 :
                      (VGA_PIXEL_Y < c_B2) ? 2'd1 : 2'd2;
    assign w_event  = VGA_VSYNC_NEG && !r_vs_hist;

    // History resets high so a VSYNC already asserted at release is not a frame end.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_vs_hist <= 1'b1;
            r_pend    <= 1'b0;
        end else begin
            r_vs_hist <= VGA_VSYNC_NEG;
            r_pend    <= w_event;
        end
    end

    // On a frame end the live counts move to the snapshot and restart from zero,
    // so a pixel qualifying on that same cycle belongs to neither frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 3; i++) begin
                r_red_cnt[i]  <= '0;
                r_blu_cnt[i]  <= '0;
                r_red_snap[i] <= '0;
                r_blu_snap[i] <= '0;
            end
            r_rth <= '0;
            r_bth <= '0;
        end else if (w_event) begin
            for (int i = 0; i < 3; i++) begin
                r_red_snap[i] <= r_red_cnt[i];
                r_blu_snap[i] <= r_blu_cnt[i];
                r_red_cnt[i]  <= '0;
                r_blu_cnt[i]  <= '0;
            end
            r_rth <= R_THRESH;
            r_bth <= B_THRESH;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_red && (w_band == 2'(i)) && (r_red_cnt[i] != c_MAX))
                    r_red_cnt[i] <= r_red_cnt[i] + 1'b1;
                if (w_blue && (w_band == 2'(i)) && (r_blu_cnt[i] != c_MAX))
                    r_blu_cnt[i] <= r_blu_cnt[i] + 1'b1;
            end
        end
    end

    logic [CNT_W+1:0] w_rsum;
    logic [CNT_W+1:0] w_bsum;
    logic [CNT_W-1:0] w_rtot;
    logic [CNT_W-1:0] w_btot;
    logic             w_red_ok;
    logic             w_blue_ok;
    logic [1:0]       w_color;
    logic [1:0]       w_shape;
    logic [CNT_W-1:0] w_t;
    logic [CNT_W-1:0] w_m;
    logic [CNT_W-1:0] w_b;
    logic [CNT_W-1:0] w_tot;
    logic [CNT_W-1:0] w_tol;
    logic [CNT_W-1:0] w_mx;
    logic [CNT_W-1:0] w_mn;

    assign w_rsum = {2'b00, r_red_snap[0]} + {2'b00, r_red_snap[1]} + {2'b00, r_red_snap[2]};
    assign w_bsum = {2'b00, r_blu_snap[0]} + {2'b00, r_blu_snap[1]} + {2'b00, r_blu_snap[2]};
    assign w_rtot = (w_rsum > {2'b00, c_MAX}) ? c_MAX : w_rsum[CNT_W-1:0];
    assign w_btot = (w_bsum > {2'b00, c_MAX}) ? c_MAX : w_bsum[CNT_W-1:0];
    assign w_red_ok  = w_rtot > r_rth;
    assign w_blue_ok = w_btot > r_bth;

    always_comb begin
        w_color = c_COL_NONE;
        if (w_red_ok && w_blue_ok)
            w_color = (w_rtot >= w_btot) ? c_COL_RED : c_COL_BLUE;
        else if (w_red_ok)
            w_color = c_COL_RED;
        else if (w_blue_ok)
            w_color = c_COL_BLUE;
    end

    always_comb begin
        w_t   = (w_color == c_COL_BLUE) ? r_blu_snap[0] : r_red_snap[0];
        w_m   = (w_color == c_COL_BLUE) ? r_blu_snap[1] : r_red_snap[1];
        w_b   = (w_color == c_COL_BLUE) ? r_blu_snap[2] : r_red_snap[2];
        w_tot = (w_color == c_COL_BLUE) ? w_btot : w_rtot;
        w_tol = w_tot >> TOL_SHIFT;
        w_mx  = w_t;
        w_mn  = w_t;
        if (w_m > w_mx) w_mx = w_m;
        if (w_b > w_mx) w_mx = w_b;
        if (w_m < w_mn) w_mn = w_m;
        if (w_b < w_mn) w_mn = w_b;
        w_shape = c_SHP_UNK;
        if (w_color == c_COL_NONE)
            w_shape = c_SHP_UNK;
        else if ((w_mx - w_mn) <= w_tol)
            w_shape = c_SHP_SQR;
        else if ((w_t < w_m) && (w_m < w_b))
            w_shape = c_SHP_TRI;
        else if ((w_m > w_t) && (w_m > w_b))
            w_shape = c_SHP_DIA;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RESULT_COLOR <= 2'b00;
            RESULT_SHAPE <= 2'b00;
            RESULT_VALID <= 1'b0;
            FRAME_CNT    <= 8'd0;
        end else if (r_pend) begin
            RESULT_COLOR <= w_color;
            RESULT_SHAPE <= w_shape;
            RESULT_VALID <= 1'b1;
            FRAME_CNT    <= FRAME_CNT + 8'd1;
        end else begin
            RESULT_VALID <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: doc/color_shape_classifier.md
Name: color_shape_classifier

Overview:
- Per-frame colour and shape classifier. It sits between the camera/VGA pixel stream and the Arduino result interface.
- Counts red and blue pixels inside a parametrised rectangular region of interest (ROI), split into three horizontal bands. Compares the totals against runtime thresholds.
- At every frame end, emits a colour code plus a shape code derived from the band-count profile, with a one-cycle valid strobe.

Parameters:
- SCREEN_WIDTH, 176, pixel columns (documentation/assertion only).
- SCREEN_HEIGHT, 144, pixel rows (documentation/assertion only).
- ROI_X0, 38, first ROI column (inclusive).
- ROI_X1, 138, ROI column end (exclusive).
- ROI_Y0, 24, first ROI row (inclusive).
- ROI_Y1, 120, ROI row end (exclusive); ROI_Y1-ROI_Y0 must be ≥3.
- CNT_W, 16, width of every counter and threshold.
- R_MIN, 3'd4, minimum PIXEL_IN[7:5] for a pixel to be red.
- B_MIN, 2'd2, minimum PIXEL_IN[1:0] for a pixel to be blue.
- TOL_SHIFT, 3, square tolerance = winner total >> TOL_SHIFT.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- PIXEL_IN  in  8  RGB332 pixel (R=[7:5], G=[4:2], B=[1:0]).
- VGA_PIXEL_X  in  10  current pixel column.
- VGA_PIXEL_Y  in  10  current pixel row.
- VGA_HREF_NEG  in  1  pixel valid when 1.
- VGA_VSYNC_NEG  in  1  rising edge marks frame end.
- R_THRESH  in  CNT_W  red total threshold, sampled at frame end.
- B_THRESH  in  CNT_W  blue total threshold, sampled at frame end.
- RESULT_COLOR  out  2  00 none, 01 red, 10 blue.
- RESULT_SHAPE  out  2  00 unknown, 01 triangle, 10 square, 11 diamond.
- RESULT_VALID  out  1  one-cycle strobe when RESULT_* update.
- FRAME_CNT  out  8  frames classified, wraps 255→0.

Behaviour:
- Reset (async assert, sync release):
  - All counters, snapshots, RESULT_*, FRAME_CNT and RESULT_VALID clear to 0.
  - The VSYNC history register resets to 1, so VSYNC already high at release does not produce a frame-end event.
- Pixel qualification, evaluated every cycle:
  - in_roi = X∈[ROI_X0,ROI_X1) and Y∈[ROI_Y0,ROI_Y1).
  - A pixel counts only when VGA_HREF_NEG=1 and in_roi=1.
  - Red = R≥R_MIN and B<B_MIN.
  - Blue = B≥B_MIN and R<R_MIN.
  - Anything else is ignored.
- Bands:
  - BAND_H = (ROI_Y1-ROI_Y0)/3.
  - Band 0 if Y<ROI_Y0+BAND_H; band 1 if Y<ROI_Y0+2·BAND_H; otherwise band 2, which absorbs the remainder.
- Live counters:
  - Six counters (red/blue × band 0..2), CNT_W bits each.
  - Each saturates at all-ones and never wraps.
  - Totals are computed CNT_W+2 bits wide, then saturated to CNT_W.
- Frame-end event:
  - Occurs when VGA_VSYNC_NEG=1 and history=0 at a posedge.
  - Edge detection is independent of the ROI.
  - History updates every cycle.
- Pipeline:
  - Event edge E: snapshot ← live counts; live counts ← 0; thresholds latched. Any pixel qualifying on the event cycle is dropped.
  - Edge E+1: RESULT_COLOR/SHAPE updated; RESULT_VALID=1 for exactly one cycle; FRAME_CNT increments.
  - Outputs hold between events.
- Colour decision:
  - red_ok = Rtot>R_THRESH; blue_ok = Btot>B_THRESH (both strict).
  - Both true → larger total wins; a tie goes to red.
  - One true → that colour.
  - Neither → 00.
- Shape decision (winner bands t,m,b; tol = winner total>>TOL_SHIFT), first match wins:
  - max−min ≤ tol → square.
  - t<m<b → triangle.
  - m>t and m>b → diamond.
  - Otherwise → 00.
  - Colour 00 forces shape 00.
- Simultaneous events:
  - Back-to-back VSYNC edges two cycles apart are handled; each event produces one strobe.
  - An event cannot occur on consecutive cycles.
- Reset mid-frame: partial counts are discarded; no strobe is produced until the next full event.

Test Plan:
- Full 100×96 ROI of 0xE0 (red), thresholds 2000/4000, VSYNC rise → two cycles later: COLOR=01, SHAPE=10 (bands 3200 each), VALID one cycle, FRAME_CNT=1.
- Red rows of width 10/40/80 px in bands 0/1/2 (counts 320/1280/2560, total 4160, tol 520) → COLOR=01, SHAPE=01.
- Blue 0x03 widths 10/80/10 (320/2560/320, total 3200), B_THRESH=3000 → COLOR=10, SHAPE=11. Repeat with B_THRESH=3200 → COLOR=00, SHAPE=00.
- Full-screen red with CNT_W=8 → every counter saturates at 255, no wrap; also verify pixels outside the ROI and with HREF=0 are not counted (an all-red frame outside the ROI gives 00).
- VSYNC held high through reset release → no VALID; RST_N pulsed mid-frame after 5000 red pixels, then a clean frame of 1000 red pixels (R_THRESH=2000) → COLOR=00, proving the cleared state.
- Red and blue totals both 4500, thresholds 2000/2000 → COLOR=01 (tie to red); 256 consecutive frames → FRAME_CNT wraps to 0.
